// File: rtl/lsu.sv
// lsu: memory-stage load/store unit; optional misalignment trap via LSU_MISALIGN_TRAP_EN
module lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_load,
  input  logic                  ex_store,
  input  logic [2:0]            ex_funct3,
  input  logic [ADDR_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  input  logic [4:0]            ex_rd,
  output logic                  lsu_stall,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  misalign
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [4:0] rd_q;
  logic accept, mis, issue, is_byte, is_half;
  logic [1:0] off;
  logic [3:0] be_n;
  logic [DATA_WIDTH-1:0] wdata_n, ld_data;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  assign off = ex_addr[1:0];
  assign accept = (state == IDLE) & ex_valid & (ex_load | ex_store);
  // Access size; undefined encodings fall through to word
  assign is_byte = ex_load ? (ex_funct3 == 3'b000 || ex_funct3 == 3'b100) : (ex_funct3 == 3'b000);
  assign is_half = ex_load ? (ex_funct3 == 3'b001 || ex_funct3 == 3'b101) : (ex_funct3 == 3'b001);
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = accept & ((is_half & off[0]) | (!is_byte & !is_half & (off != 2'b00)));
`else
  assign mis = 1'b0;
`endif
  assign issue = accept & !mis;
  assign lsu_stall = (state != IDLE) | issue;
  assign be_n = ex_load ? 4'b1111 : is_byte ? (4'b0001 << off) : is_half ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_n = is_byte ? {4{ex_wdata[7:0]}} : is_half ? {2{ex_wdata[15:0]}} : ex_wdata;
  assign byte_sel = mem_rdata[8*off_q +: 8];
  assign half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ld_data = (f3_q == 3'b000) ? {{24{byte_sel[7]}}, byte_sel} :
                   (f3_q == 3'b001) ? {{16{half_sel[15]}}, half_sel} :
                   (f3_q == 3'b100) ? {24'd0, byte_sel} :
                   (f3_q == 3'b101) ? {16'd0, half_sel} : mem_rdata;
  // Access FSM with registered memory and writeback outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      misalign  <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      rd_q      <= '0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= mis;
      case (state)
        IDLE: if (issue) begin
          state     <= REQ;
          mem_req   <= 1'b1;
          mem_we    <= ex_store;
          mem_be    <= be_n;
          mem_addr  <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata <= wdata_n;
          f3_q      <= ex_funct3;
          off_q     <= off;
          rd_q      <= ex_rd;
        end
        REQ: if (mem_gnt) begin
          mem_req <= 1'b0;
          state   <= mem_we ? IDLE : WAIT;
        end
        WAIT: if (mem_rvalid) begin
          wb_valid <= 1'b1;
          wb_data  <= ld_data;
          wb_rd    <= rd_q;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu with a transaction-level model
module tb_lsu;
  logic clk = 0, rst_n = 0;
  logic ex_valid, ex_load, ex_store, mem_gnt, mem_rvalid;
  logic [2:0] ex_funct3;
  logic [31:0] ex_addr, ex_wdata, mem_rdata;
  logic [4:0] ex_rd;
  logic lsu_stall, mem_req, mem_we, wb_valid, misalign;
  logic [3:0] mem_be;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [4:0] wb_rd;
  int n_cmp = 0, n_fail = 0;
  logic exp_req = 0, exp_wb = 0, exp_mis = 0, exp_we = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_data = 0, cap_addr = 0, cap_wdata = 0, cap_wb = 0;
  logic [3:0] exp_be = 0, cap_be = 0;
  logic [4:0] exp_rd = 0;
  always #5 clk = ~clk;
  lsu dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .lsu_stall(lsu_stall), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [3:0] m_be(input logic ld, input logic [2:0] f3, input logic [31:0] a);
    int off = int'(a % 4);
    if (ld) return 4'hF;
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction
  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'd0) return (wd & 32'hFF) * 32'h01010101;
    if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int off = int'(a % 4);
    logic [31:0] b = (w >> (8 * off)) & 32'hFF;
    logic [31:0] h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? b - 32'd256 : b;
      3'd1: return (h >= 32768) ? h - 32'd65536 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction
  // Per-cycle comparison of DUT outputs against the model's expectations
  always @(negedge clk) if (rst_n) begin
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    chk("wb_valid", 32'(wb_valid), 32'(exp_wb));
    chk("misalign", 32'(misalign), 32'(exp_mis));
    if (mem_req) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_be", 32'(mem_be), 32'(exp_be));
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata;
    end
    if (wb_valid) begin
      chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
      chk("wb_data", wb_data, exp_data);
      cap_wb = wb_data;
    end
  end
  task automatic access(input logic ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input int dly, input logic [31:0] rdata);
    exp_we = !ld; exp_addr = a & ~32'h3; exp_be = m_be(ld, f3, a); exp_wdata = m_wdata(f3, wd);
    exp_rd = rd; exp_data = m_load(f3, a, rdata);
    ex_valid = 1; ex_load = ld; ex_store = !ld; ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    #1 chk("stall_accept", 32'(lsu_stall), 1);
    @(posedge clk); #1;
    ex_valid = 0; ex_load = 0; ex_store = 0; exp_req = 1;
    for (int i = 0; i < dly; i++) begin
      chk("stall_req", 32'(lsu_stall), 1);
      @(posedge clk); #1;
    end
    mem_gnt = 1;
    chk("stall_gnt", 32'(lsu_stall), 1);
    @(posedge clk); #1;
    mem_gnt = 0; exp_req = 0;
    if (!ld) chk("stall_done", 32'(lsu_stall), 0);
    else begin
      chk("stall_wait", 32'(lsu_stall), 1);
      mem_rvalid = 1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_rvalid = 0; exp_wb = 1;
      chk("stall_wb", 32'(lsu_stall), 0);
      @(posedge clk); #1;
      exp_wb = 0;
    end
  endtask
  initial begin
    ex_valid = 0; ex_load = 0; ex_store = 0; ex_funct3 = 0; ex_addr = 0; ex_wdata = 0; ex_rd = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #2;
    chk("rst_req", 32'(mem_req), 0); chk("rst_we", 32'(mem_we), 0); chk("rst_be", 32'(mem_be), 0);
    chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0); chk("rst_wb", 32'(wb_valid), 0);
    chk("rst_rd", 32'(wb_rd), 0); chk("rst_data", wb_data, 0); chk("rst_mis", 32'(misalign), 0);
    chk("rst_stall", 32'(lsu_stall), 0);
    #5 rst_n = 1;
    @(posedge clk); #1;
    chk("model_be_sb", 32'(m_be(0, 3'd0, 32'h1003)), 32'h8);
    chk("model_wd_sb", m_wdata(3'd0, 32'hA5), 32'hA5A5A5A5);
    chk("model_lb", m_load(3'd0, 32'h2001, 32'h000080FF), 32'hFFFFFF80);
    chk("model_lbu", m_load(3'd4, 32'h2001, 32'h000080FF), 32'h00000080);
    chk("model_lh", m_load(3'd1, 32'h2002, 32'h80011234), 32'hFFFF8001);
    chk("model_lhu", m_load(3'd5, 32'h2002, 32'h80011234), 32'h00008001);
    access(0, 3'd0, 32'h1003, 32'h000000A5, 5'd0, 0, 0);
    chk("sb_addr", cap_addr, 32'h1000); chk("sb_be", 32'(cap_be), 32'h8); chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    access(1, 3'd0, 32'h2001, 0, 5'd7, 0, 32'h000080FF);
    chk("lb_data", cap_wb, 32'hFFFFFF80);
    access(1, 3'd4, 32'h2001, 0, 5'd7, 0, 32'h000080FF);
    chk("lbu_data", cap_wb, 32'h00000080);
    access(1, 3'd1, 32'h2002, 0, 5'd9, 0, 32'h80011234);
    chk("lh_data", cap_wb, 32'hFFFF8001);
    access(1, 3'd5, 32'h2002, 0, 5'd9, 0, 32'h80011234);
    chk("lhu_data", cap_wb, 32'h00008001);
    access(0, 3'd2, 32'h40, 32'hDEADBEEF, 5'd0, 3, 0);
    chk("sw_be", 32'(cap_be), 32'hF); chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
    access(0, 3'd1, 32'h12, 32'h1234ABCD, 5'd0, 1, 0);
    chk("sh_be", 32'(cap_be), 32'hC); chk("sh_wdata", cap_wdata, 32'hABCDABCD);
    access(1, 3'd2, 32'h100, 0, 5'd31, 2, 32'h12345678);
    access(1, 3'd3, 32'h104, 0, 5'd1, 0, 32'h87654321);
    chk("ld_undef", cap_wb, 32'h87654321);
    access(0, 3'd7, 32'h200, 32'h0BADF00D, 5'd0, 0, 0);
    chk("st_undef_be", 32'(cap_be), 32'hF);
    access(1, 3'd0, 32'h3002, 0, 5'd4, 0, 32'h00C30000);
    chk("lb_off2", cap_wb, 32'hFFFFFFC3);
`ifdef LSU_MISALIGN_TRAP_EN
    ex_valid = 1; ex_load = 1; ex_store = 0; ex_funct3 = 3'd2; ex_addr = 32'h42;
    #1 chk("mis_stall", 32'(lsu_stall), 0);
    @(posedge clk); #1;
    ex_valid = 0; ex_load = 0; exp_mis = 1;
    chk("mis_pulse", 32'(misalign), 1);
    @(posedge clk); #1;
    exp_mis = 0;
    chk("mis_clear", 32'(misalign), 0); chk("mis_noreq", 32'(mem_req), 0);
`else
    access(1, 3'd2, 32'h42, 0, 5'd3, 0, 32'hCAFEF00D);
    chk("lw_mis_addr", cap_addr, 32'h40); chk("lw_mis_be", 32'(cap_be), 32'hF);
    chk("lw_mis_data", cap_wb, 32'hCAFEF00D);
`endif
    mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_rvalid = 0;
    chk("stray_rvalid", 32'(wb_valid), 0);
    exp_we = 0; exp_addr = 32'h80; exp_be = 4'hF; exp_rd = 5'd5;
    ex_valid = 1; ex_load = 1; ex_funct3 = 3'd2; ex_addr = 32'h80; ex_rd = 5'd5;
    @(posedge clk); #1;
    ex_valid = 0; ex_load = 0; exp_req = 1; mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0; exp_req = 0;
    #1 rst_n = 0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 0); chk("mid_rst_addr", mem_addr, 0); chk("mid_rst_be", 32'(mem_be), 0);
    chk("mid_rst_we", 32'(mem_we), 0); chk("mid_rst_stall", 32'(lsu_stall), 0);
    chk("mid_rst_wb", 32'(wb_valid), 0); chk("mid_rst_rd", 32'(wb_rd), 0);
    #1 rst_n = 1;
    @(posedge clk); #1;
    mem_rvalid = 1; mem_rdata = 32'h11111111;
    @(posedge clk); #1;
    mem_rvalid = 0;
    chk("post_rst_wb", 32'(wb_valid), 0);
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
